// File: rtl/dcp_noc2_enc_pkg.sv
// Shared types, constants and helpers for the DCP NOC2 flit encoder.
package dcp_noc2_enc_pkg;

  localparam logic [7:0] DCP_NOC2_LOAD_REQ64 = 8'd14;
  localparam logic [7:0] DCP_NOC2_LOAD_ACK   = 8'd24;
  localparam logic [7:0] DCP_NOC2_STORE_ACK  = 8'd25;

  localparam int unsigned FLIT_W     = 64;
  localparam int unsigned CHIPID_LSB = 50;
  localparam int unsigned CHIPID_W   = 14;
  localparam int unsigned X_LSB      = 42;
  localparam int unsigned Y_LSB      = 34;
  localparam int unsigned XY_W       = 8;
  localparam int unsigned FBITS_LSB  = 30;
  localparam int unsigned FBITS_FW   = 4;
  localparam int unsigned LEN_LSB    = 22;
  localparam int unsigned LEN_W      = 8;
  localparam int unsigned TYPE_LSB   = 14;
  localparam int unsigned TYPE_W     = 8;
  localparam int unsigned MSHRID_LSB = 6;
  localparam int unsigned MSHRID_FW  = 8;
  localparam int unsigned SIZE_LSB   = 27;
  localparam int unsigned SIZE_W     = 3;
  localparam logic [2:0]  SIZE_8B    = 3'b011;

  typedef struct packed {
    logic [13:0] chipid;
    logic [7:0]  x;
    logic [7:0]  y;
  } homeid_t;

  typedef enum logic [1:0] {StIdle, StHdr, StBody} state_e;

  // Fields are sized to the widest supported input; narrower inputs are zero-extended.
  typedef struct packed {
    logic [7:0]  mtype;
    logic [7:0]  mshrid;
    logic [63:0] addr;
    logic [63:0] data;
    logic [29:0] homeid;
    logic [3:0]  fbits;
  } msg_t;

  localparam int unsigned MSG_W = $bits(msg_t);

  function automatic homeid_t unpack_homeid(input logic [29:0] homeid);
    homeid_t h;
    h.chipid = homeid[29:16];
    h.x      = homeid[15:8];
    h.y      = homeid[7:0];
    return h;
  endfunction

  function automatic logic known_type(input logic [7:0] t);
    return (t == DCP_NOC2_LOAD_REQ64) || (t == DCP_NOC2_LOAD_ACK) || (t == DCP_NOC2_STORE_ACK);
  endfunction

  function automatic logic [7:0] msg_len(input logic [7:0] t);
    logic [7:0] len;
    case (t)
      DCP_NOC2_LOAD_REQ64: len = 8'd2;
      DCP_NOC2_LOAD_ACK:   len = 8'd1;
      default:             len = 8'd0;
    endcase
    return len;
  endfunction

endpackage

// File: rtl/dcp_noc2_msg_reg.sv
// One-entry message register; a write in the same cycle as a pop replaces the entry.
module dcp_noc2_msg_reg
  import dcp_noc2_enc_pkg::*;
(
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_val_i,
  input  logic [MSG_W-1:0] in_msg_i,
  input  logic             out_rdy_i,
  output logic             out_val_o,
  output logic [MSG_W-1:0] out_msg_o
);

  logic             full_q, full_d;
  logic [MSG_W-1:0] msg_q, msg_d;

  always_comb begin
    full_d = full_q;
    msg_d  = msg_q;
    if (out_rdy_i) full_d = 1'b0;
    if (in_val_i) begin
      full_d = 1'b1;
      msg_d  = in_msg_i;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      full_q <= 1'b0;
      msg_q  <= '0;
    end else begin
      full_q <= full_d;
      msg_q  <= msg_d;
    end
  end

  assign out_val_o = full_q;
  assign out_msg_o = msg_q;

endmodule

// File: rtl/dcp_noc2_encoder.sv
// Serializes DCP NOC2 messages into 64-bit flits. Define DCP_NOC2_ENC_SKID_EN for a
// second message register that removes the IDLE bubble between back-to-back messages.
module dcp_noc2_encoder
  import dcp_noc2_enc_pkg::*;
#(
  parameter int unsigned NOC_WIDTH = 64,
  parameter int unsigned MSHRID_W  = 8,
  parameter int unsigned PADDR_W   = 40,
  parameter int unsigned HOMEID_W  = 30,
  parameter int unsigned FBITS_W   = 4,
  parameter int unsigned MY_X      = 0,
  parameter int unsigned MY_Y      = 0,
  parameter int unsigned MY_CHIPID = 0
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 dcp_noc2buffer_val,
  output logic                 dcp_noc2buffer_rdy,
  input  logic [7:0]           dcp_noc2buffer_type,
  input  logic [MSHRID_W-1:0]  dcp_noc2buffer_mshrid,
  input  logic [PADDR_W-1:0]   dcp_noc2buffer_address,
  input  logic [63:0]          dcp_noc2buffer_data,
  input  logic [HOMEID_W-1:0]  dcp_noc2buffer_homeid,
  input  logic [FBITS_W-1:0]   dcp_noc2buffer_fbits,
  output logic                 noc2_out_val,
  input  logic                 noc2_out_rdy,
  output logic [NOC_WIDTH-1:0] noc2_out_data,
  output logic                 enc_err_pulse
);

  state_e            state_q, state_d;
  logic [7:0]        cnt_q, cnt_d;
  logic              rst_done_q, rst_done_d;
  logic              err_q, err_d;
  logic              accept, accept_ok, take, pop;
  logic              head_val, head_wr;
  msg_t              head_msg, head_wdata, in_msg;
  homeid_t           hid;
  logic [7:0]        len;
  logic [FLIT_W-1:0] flit0, flit1, flit2, flit;

`ifdef DCP_NOC2_ENC_SKID_EN
  logic tail_val, tail_wr, tail_rd;
  msg_t tail_msg;
  assign dcp_noc2buffer_rdy = rst_done_q && !tail_val;
`else
  assign dcp_noc2buffer_rdy = rst_done_q && (state_q == StIdle);
`endif

  assign accept    = dcp_noc2buffer_val && dcp_noc2buffer_rdy;
  assign accept_ok = accept && known_type(dcp_noc2buffer_type);

  always_comb begin
    in_msg        = '0;
    in_msg.mtype  = dcp_noc2buffer_type;
    in_msg.mshrid = 8'(dcp_noc2buffer_mshrid);
    in_msg.addr   = 64'(dcp_noc2buffer_address);
    in_msg.data   = dcp_noc2buffer_data;
    in_msg.homeid = 30'(dcp_noc2buffer_homeid);
    in_msg.fbits  = 4'(dcp_noc2buffer_fbits);
  end

  always_comb begin
    hid   = unpack_homeid(head_msg.homeid);
    len   = msg_len(head_msg.mtype);
    flit0 = '0;
    flit0[CHIPID_LSB +: CHIPID_W] = hid.chipid;
    flit0[X_LSB +: XY_W]          = hid.x;
    flit0[Y_LSB +: XY_W]          = hid.y;
    flit0[FBITS_LSB +: FBITS_FW]  = head_msg.fbits;
    flit0[LEN_LSB +: LEN_W]       = len;
    flit0[TYPE_LSB +: TYPE_W]     = head_msg.mtype;
    flit0[MSHRID_LSB +: MSHRID_FW] = head_msg.mshrid;
    flit1 = (head_msg.mtype == DCP_NOC2_LOAD_REQ64) ? head_msg.addr : head_msg.data;
    // Return-path header for the memory reply, pointing back at this tile.
    flit2 = '0;
    flit2[CHIPID_LSB +: CHIPID_W] = 14'(MY_CHIPID);
    flit2[X_LSB +: XY_W]          = 8'(MY_X);
    flit2[Y_LSB +: XY_W]          = 8'(MY_Y);
    flit2[SIZE_LSB +: SIZE_W]     = SIZE_8B;
  end

  assign noc2_out_val  = (state_q != StIdle) && head_val;
  assign noc2_out_data = NOC_WIDTH'(flit);
  assign enc_err_pulse = err_q;

  always_comb begin
    state_d    = state_q;
    cnt_d      = cnt_q;
    pop        = 1'b0;
    flit       = '0;
    rst_done_d = 1'b1;
    err_d      = accept && !known_type(dcp_noc2buffer_type);
    take       = noc2_out_val && noc2_out_rdy;
    unique case (state_q)
      StHdr: begin
        flit = flit0;
        if (take) begin
          if (len == 8'd0) begin
            pop     = 1'b1;
            state_d = StIdle;
          end else begin
            state_d = StBody;
            cnt_d   = 8'd1;
          end
        end
      end
      StBody: begin
        flit = (cnt_q == 8'd1) ? flit1 : flit2;
        if (take) begin
          if (cnt_q == len) begin
            pop     = 1'b1;
            state_d = StIdle;
          end else begin
            cnt_d = cnt_q + 8'd1;
          end
        end
      end
      default: ;
    endcase
`ifdef DCP_NOC2_ENC_SKID_EN
    // Head refills from the tail (or straight from the input) on the last flit.
    head_wr    = (pop && tail_val) || (accept_ok && (!head_val || (pop && !tail_val)));
    head_wdata = tail_val ? tail_msg : in_msg;
    tail_wr    = accept_ok && head_val && !pop;
    tail_rd    = pop && tail_val;
`else
    head_wr    = accept_ok;
    head_wdata = in_msg;
`endif
    if (head_wr) begin
      state_d = StHdr;
      cnt_d   = 8'd0;
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= StIdle;
      cnt_q      <= 8'd0;
      rst_done_q <= 1'b0;
      err_q      <= 1'b0;
    end else begin
      state_q    <= state_d;
      cnt_q      <= cnt_d;
      rst_done_q <= rst_done_d;
      err_q      <= err_d;
    end
  end

  dcp_noc2_msg_reg u_msg_head (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_val_i  (head_wr),
    .in_msg_i  (head_wdata),
    .out_rdy_i (pop),
    .out_val_o (head_val),
    .out_msg_o (head_msg)
  );

`ifdef DCP_NOC2_ENC_SKID_EN
  dcp_noc2_msg_reg u_msg_tail (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_val_i  (tail_wr),
    .in_msg_i  (in_msg),
    .out_rdy_i (tail_rd),
    .out_val_o (tail_val),
    .out_msg_o (tail_msg)
  );
`endif

endmodule
